// File: rtl/reg_access_ctrl_if.sv
// Requester-side configuration bus: select/ack handshake carrying one
// read or write transaction at a time.
interface reg_access_ctrl_if;
    logic       mem_sel_en;
    logic       mem_wr_rd_s;
    logic [7:0] mem_addr;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;
    logic       mem_ack;
    logic       mem_err;

    modport master (
        output mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data,
        input  mem_rd_data, mem_ack, mem_err
    );

    modport slave (
        input  mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data,
        output mem_rd_data, mem_ack, mem_err
    );
endinterface

// File: rtl/reg_access_ctrl.sv
// Configuration-bus controller: decodes single transactions from the
// requester into one-hot write pulses or read-back muxing for four 8-bit
// configuration registers. Unmapped addresses complete with an error flag.
module reg_access_ctrl #(
    parameter int unsigned NUM_OF_REG = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    reg_access_ctrl_if.slave        bus,
    output logic                    cfg_busy,
    output logic [7:0]              wr_en,
    output logic [7:0]              wr_data,
    input  logic [7:0]              reg_data_0,
    input  logic [7:0]              reg_data_1,
    input  logic [7:0]              reg_data_2,
    input  logic [7:0]              reg_data_3
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] RESP     = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [7:0]            addr_q, addr_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [7:0]            wr_en_q, wr_en_d;
    logic [NUM_OF_REG-1:0] hit;

    // Byte address to one-hot register select; all-zero means unmapped.
    function automatic logic [NUM_OF_REG-1:0] decode(input logic [7:0] a);
        logic [NUM_OF_REG-1:0] s;
        s = '0;
        case (a)
            8'h00:   s[0] = 1'b1;
            8'h02:   s[1] = 1'b1;
            8'h04:   s[2] = 1'b1;
            8'h08:   s[3] = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    assign hit = decode(addr_q);

    // Next-state logic. The write pulse is decoded from the live address
    // at the accept edge so that wr_en is itself a register and is high
    // exactly during ACCESS.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_rd_d = wr_rd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        wr_en_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.mem_sel_en) begin
                    addr_d  = bus.mem_addr;
                    wr_rd_d = bus.mem_wr_rd_s;
                    wdata_d = bus.mem_wr_data;
                    if (bus.mem_wr_rd_s) begin
                        wr_en_d = {{(8-NUM_OF_REG){1'b0}}, decode(bus.mem_addr)};
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ack_d   = 1'b1;
                err_d   = (hit == '0);
                rdata_d = 8'h00;
                if (!wr_rd_q) begin
                    rdata_d = ({8{hit[0]}} & reg_data_0) |
                              ({8{hit[1]}} & reg_data_1) |
                              ({8{hit[2]}} & reg_data_2) |
                              ({8{hit[3]}} & reg_data_3);
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = bus.mem_sel_en ? WAIT_REL : IDLE;
            end
            WAIT_REL: begin
                if (!bus.mem_sel_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_rd_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            wr_en_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_rd_q <= wr_rd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign bus.mem_rd_data = rdata_q;
    assign bus.mem_ack     = ack_q;
    assign bus.mem_err     = err_q;
    assign wr_en           = wr_en_q;
    assign wr_data         = wdata_q;
    assign cfg_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench for reg_access_ctrl: directed vector table, multi-cycle
// corner sequences and randomized transactions against a transaction-level
// model of the four configuration registers.
module tb_reg_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_busy;
    logic [7:0] wr_en;
    logic [7:0] wr_data;
    logic [7:0] regfile [4];

    reg_access_ctrl_if bus ();

    reg_access_ctrl #(.NUM_OF_REG(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .cfg_busy   (cfg_busy),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .reg_data_0 (regfile[0]),
        .reg_data_1 (regfile[1]),
        .reg_data_2 (regfile[2]),
        .reg_data_3 (regfile[3])
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int wen_cycles = 0;
    int ack_cycles = 0;

    // Reference register contents, updated per completed transaction.
    logic [7:0] mref [4];
    logic [7:0] addr_map [4] = '{8'h00, 8'h02, 8'h04, 8'h08};

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] data;
        logic       exp_err;
        logic [7:0] exp_rd;
        logic [7:0] exp_wen;
    } vec_t;

    vec_t tbl [13];

    // Register block model driven by the DUT write port.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) regfile[i] <= wr_data;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: pulse counting and one-hot legality of wr_en.
    always @(negedge clk) begin
        if (wr_en != 8'h00) begin
            wen_cycles++;
            chk("wen_onehot", {7'b0, ($countones(wr_en) == 1) && (wr_en[7:4] == 4'h0)}, 8'h01);
        end
        if (bus.mem_ack) ack_cycles++;
    end

    function automatic int idx_of(input logic [7:0] a);
        for (int i = 0; i < 4; i++) begin
            if (addr_map[i] == a) return i;
        end
        return -1;
    endfunction

    // One transaction with select dropped on ack; entered and left in IDLE,
    // 1 time unit after a rising edge.
    task automatic txn(input logic [7:0] a, input logic w, input logic [7:0] d,
                       input logic exp_err, input logic [7:0] exp_rd,
                       input logic [7:0] exp_wen);
        logic [7:0] junk;
        int         idx;
        bus.mem_sel_en  = 1'b1;
        bus.mem_addr    = a;
        bus.mem_wr_rd_s = w;
        bus.mem_wr_data = d;
        @(posedge clk); #1;
        // Post-latch input changes must be ignored.
        junk = 8'($urandom);
        bus.mem_addr    = junk;
        bus.mem_wr_data = ~junk;
        bus.mem_wr_rd_s = junk[0];
        chk("access_wen", wr_en, exp_wen);
        chk("access_wdata", wr_data, d);
        chk("access_ack", {7'b0, bus.mem_ack}, 8'h00);
        chk("access_busy", {7'b0, cfg_busy}, 8'h01);
        @(posedge clk); #1;
        chk("resp_ack", {7'b0, bus.mem_ack}, 8'h01);
        chk("resp_err", {7'b0, bus.mem_err}, {7'b0, exp_err});
        chk("resp_rd", bus.mem_rd_data, exp_rd);
        chk("resp_wen", wr_en, 8'h00);
        bus.mem_sel_en = 1'b0;
        @(posedge clk); #1;
        chk("idle_ack", {7'b0, bus.mem_ack}, 8'h00);
        chk("idle_busy", {7'b0, cfg_busy}, 8'h00);
        chk("idle_wdata_hold", wr_data, d);
        idx = idx_of(a);
        if (w && idx >= 0) mref[idx] = d;
    endtask

    // Random transaction whose expectations come from the register model.
    task automatic rand_txn();
        logic [7:0] a, d, exp_rd, exp_wen;
        logic       w;
        int         idx;
        a = 8'($urandom);
        if ($urandom_range(0, 2) != 0) a = addr_map[$urandom_range(0, 3)];
        w = 1'($urandom);
        d = 8'($urandom);
        idx     = idx_of(a);
        exp_rd  = (!w && idx >= 0) ? mref[idx] : 8'h00;
        exp_wen = (w && idx >= 0) ? (8'h01 << idx) : 8'h00;
        txn(a, w, d, idx < 0, exp_rd, exp_wen);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            regfile[i] = 8'h00;
            mref[i]    = 8'h00;
        end
        tbl[0]  = '{8'h04, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h04};
        tbl[1]  = '{8'h04, 1'b0, 8'h00, 1'b0, 8'hA5, 8'h00};
        tbl[2]  = '{8'h00, 1'b1, 8'h11, 1'b0, 8'h00, 8'h01};
        tbl[3]  = '{8'h02, 1'b1, 8'h22, 1'b0, 8'h00, 8'h02};
        tbl[4]  = '{8'h04, 1'b1, 8'h33, 1'b0, 8'h00, 8'h04};
        tbl[5]  = '{8'h08, 1'b1, 8'h44, 1'b0, 8'h00, 8'h08};
        tbl[6]  = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h11, 8'h00};
        tbl[7]  = '{8'h02, 1'b0, 8'h00, 1'b0, 8'h22, 8'h00};
        tbl[8]  = '{8'h04, 1'b0, 8'h00, 1'b0, 8'h33, 8'h00};
        tbl[9]  = '{8'h08, 1'b0, 8'h00, 1'b0, 8'h44, 8'h00};
        tbl[10] = '{8'h01, 1'b1, 8'hFF, 1'b1, 8'h00, 8'h00};
        tbl[11] = '{8'h06, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00};
        tbl[12] = '{8'h08, 1'b0, 8'h00, 1'b0, 8'h44, 8'h00};

        // Reset held two cycles with a pending write request.
        rst_n           = 1'b0;
        bus.mem_sel_en  = 1'b1;
        bus.mem_wr_rd_s = 1'b1;
        bus.mem_addr    = 8'h00;
        bus.mem_wr_data = 8'h5A;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_wen", wr_en, 8'h00);
            chk("rst_wdata", wr_data, 8'h00);
            chk("rst_ack", {7'b0, bus.mem_ack}, 8'h00);
            chk("rst_err", {7'b0, bus.mem_err}, 8'h00);
            chk("rst_rd", bus.mem_rd_data, 8'h00);
            chk("rst_busy", {7'b0, cfg_busy}, 8'h00);
        end
        rst_n = 1'b1;
        txn(8'h00, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h01);

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            txn(tbl[i].addr, tbl[i].wr, tbl[i].data, tbl[i].exp_err, tbl[i].exp_rd, tbl[i].exp_wen);
        end

        // Select held for 6 cycles on a write: one pulse, one ack, WAIT_REL.
        begin
            int w0, a0;
            w0 = wen_cycles;
            a0 = ack_cycles;
            bus.mem_sel_en  = 1'b1;
            bus.mem_wr_rd_s = 1'b1;
            bus.mem_addr    = 8'h02;
            bus.mem_wr_data = 8'h77;
            for (int c = 1; c <= 6; c++) begin
                @(posedge clk); #1;
                chk("hold_busy", {7'b0, cfg_busy}, 8'h01);
                if (c == 2) chk("hold_ack", {7'b0, bus.mem_ack}, 8'h01);
            end
            bus.mem_sel_en = 1'b0;
            @(posedge clk); #1;
            chk("hold_release_busy", {7'b0, cfg_busy}, 8'h00);
            @(posedge clk); #1;
            chk("hold_wen_pulses", 8'(wen_cycles - w0), 8'h01);
            chk("hold_acks", 8'(ack_cycles - a0), 8'h01);
            mref[1] = 8'h77;
        end
        txn(8'h02, 1'b0, 8'h00, 1'b0, 8'h77, 8'h00);

        // Reset landing in the ACCESS cycle of a write: transaction dropped.
        begin
            int a0;
            a0 = ack_cycles;
            bus.mem_sel_en  = 1'b1;
            bus.mem_wr_rd_s = 1'b1;
            bus.mem_addr    = 8'h02;
            bus.mem_wr_data = 8'h99;
            @(posedge clk); #1;
            chk("rstacc_wen_before", wr_en, 8'h02);
            rst_n          = 1'b0;
            bus.mem_sel_en = 1'b0;
            @(posedge clk); #1;
            chk("rstacc_wen_after", wr_en, 8'h00);
            chk("rstacc_busy", {7'b0, cfg_busy}, 8'h00);
            chk("rstacc_wdata", wr_data, 8'h00);
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (2) begin
                @(posedge clk); #1;
                chk("rstacc_busy_idle", {7'b0, cfg_busy}, 8'h00);
            end
            chk("rstacc_no_ack", 8'(ack_cycles - a0), 8'h00);
        end
        // Requester reissues; register 1 then has a known value again.
        txn(8'h02, 1'b1, 8'hC3, 1'b0, 8'h00, 8'h02);

        // Randomized transactions against the model.
        for (int n = 0; n < 60; n++) begin
            rand_txn();
        end
        for (int i = 0; i < 4; i++) begin
            txn(addr_map[i], 1'b0, 8'h00, 1'b0, mref[i], 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
